peripheral_master_tl: RTL and testbench
=======================================

Name: peripheral_master_tl

Overview:
- TileLink-UL initiator: converts a simple single-beat request/response port into channel A requests and consumes channel D responses.
- It is the requesting end of the bus that the TL slave peripherals and BFMs serve. DMA engines use it as their bus master.
- One transaction outstanding at a time.
- A response watchdog reports lost responses and drops stale ones.

Parameters:
- TL_AW, 32, address width in bits
- TL_DW, 32, data width in bits
- TL_SRCW, 8, source id width in bits
- TL_SINKW, 1, sink id width in bits
- TL_DBW, TL_DW>>3, byte mask width
- TL_SZW, $clog2($clog2(TL_DBW)+1), size field width
- TIMEOUT, 1024, cycles to wait for D before error response; 0 disables the watchdog

Ports:
- clk  input  1  clock
- reset  input  1  synchronous active-high reset
- req_valid  input  1  request present
- req_ready  output  1  request accepted when high with req_valid
- req_we  input  1  1=write, 0=read
- req_addr  input  TL_AW  byte address, aligned to TL_DBW
- req_be  input  TL_DBW  write byte enables (ignored for reads)
- req_wdata  input  TL_DW  write data
- rsp_valid  output  1  single-cycle response pulse
- rsp_rdata  output  TL_DW  read data (0 for writes and errors)
- rsp_err  output  1  denied, corrupt, bad opcode or timeout
- a_opcode  output  3  channel A opcode
- a_param  output  3  channel A param
- a_size  output  TL_SZW  channel A size
- a_source  output  TL_SRCW  channel A source id
- a_address  output  TL_AW  channel A address
- a_mask  output  TL_DBW  channel A byte mask
- a_data  output  TL_DW  channel A data
- a_corrupt  output  1  channel A corrupt
- a_valid  output  1  channel A valid
- a_ready  input  1  channel A ready
- d_opcode  input  3  channel D opcode
- d_param  input  3  channel D param
- d_size  input  TL_SZW  channel D size
- d_source  input  TL_SRCW  channel D source id
- d_sink  input  TL_SINKW  channel D sink id
- d_denied  input  1  channel D denied
- d_data  input  TL_DW  channel D data
- d_corrupt  input  1  channel D corrupt
- d_valid  input  1  channel D valid
- d_ready  output  1  channel D ready

Behaviour:
- Clock and reset (decided): one clock, clk; reset is synchronous, active-high, named reset.
- Reset values:
  - req_ready=0, a_valid=0, all a_* payload=0, rsp_valid=0, rsp_rdata=0, rsp_err=0.
  - d_ready=0; it is 1 in every cycle after reset.
  - Source counter=0, watchdog=0, state=IDLE.
- FSM states: IDLE, A_REQ, D_WAIT.
- IDLE:
  - req_ready=1.
  - On req_valid, latch the request and drive a_valid=1 on the next cycle, entering A_REQ.
- A_REQ:
  - a_valid=1; payload held stable until a_ready (a_valid is never retracted).
  - On a_valid&a_ready, go to D_WAIT and clear the watchdog.
  - No watchdog in this state.
- A payload encoding:
  - Read: a_opcode=4 (Get), a_mask all ones, a_data=0.
  - Write with req_be all ones: a_opcode=0 (PutFullData).
  - Write otherwise: a_opcode=1 (PutPartialData).
  - a_param=0, a_corrupt=0, a_size=$clog2(TL_DBW), a_source=current source counter.
- D_WAIT:
  - A D beat (d_valid&d_ready) with d_source==a_source completes the transaction.
  - The next cycle is rsp_valid=1 and state returns to IDLE, so req_ready=1 in that same cycle.
  - rsp_rdata=d_data only for a successful read, else 0.
  - Source counter increments (wraps modulo 2^TL_SRCW) at completion.
- rsp_err=1 when any of the following holds:
  - d_denied=1.
  - A read with d_corrupt=1.
  - A read whose opcode is not 1 (AccessAckData).
  - A write whose opcode is not 0 (AccessAck).
- Stale responses: D beats with a source mismatch, or arriving in IDLE/A_REQ, are accepted and dropped with no rsp.
- Watchdog:
  - With TIMEOUT>0, it increments every D_WAIT cycle.
  - When it reaches TIMEOUT with no matching D, emit rsp_valid=1, rsp_err=1, rsp_rdata=0, increment the source counter, and return to IDLE. A late response is then stale and dropped.
  - If a matching D and the timeout occur in the same cycle, the D wins.
- Latency: req handshake to a_valid = 1 cycle; matching D beat to rsp_valid = 1 cycle.
- Reset mid-operation: drop everything, return to IDLE next cycle, a_valid=0 immediately.

Decomposition:
- Package peripheral_tl_pkg holds:
  - A opcode constants: PUT_FULL=0, PUT_PARTIAL=1, GET=4.
  - D opcode constants: ACCESS_ACK=0, ACCESS_ACK_DATA=1.
  - The FSM state enum.
- No sub-module needed; the watchdog is inline.

Test Plan:
- Read at 0x100, slave answers AccessAckData with data 0xDEADBEEF after 3 cycles -> a_opcode=4, a_mask=0xF, a_size=2; rsp_valid one cycle later with rsp_rdata=0xDEADBEEF, rsp_err=0.
- Write 0x12345678 with be=0xF, then be=0x3 -> a_opcode 0 then 1, a_mask 0xF then 0x3; both responses have rsp_err=0 and rsp_rdata=0; a_source goes 0 then 1.
- Hold a_ready=0 for 10 cycles -> a_valid and payload stable throughout; no timeout fires.
- TIMEOUT=16, no D response -> rsp_err=1 after 16 D_WAIT cycles; a late D with the old source is dropped; the next request uses source+1 and completes normally.
- Read answered with d_denied=1, then a read answered with d_corrupt=1, then a write answered with opcode 1 -> rsp_err=1 for all three.
- Assert reset during D_WAIT -> a_valid=0, IDLE next cycle, no rsp; source counter 0 after reset.

Source files
------------

// File: rtl/peripheral_tl_pkg.sv
// Shared TileLink-UL constants and FSM state type
// for the peripheral master.
package peripheral_tl_pkg;

  localparam logic [2:0] PUT_FULL        = 3'd0;
  localparam logic [2:0] PUT_PARTIAL     = 3'd1;
  localparam logic [2:0] GET             = 3'd4;

  localparam logic [2:0] ACCESS_ACK      = 3'd0;
  localparam logic [2:0] ACCESS_ACK_DATA = 3'd1;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_A_REQ  = 2'd1,
    S_D_WAIT = 2'd2
  } tl_state_e;

endpackage

// File: rtl/peripheral_master_tl.sv
// TileLink-UL single-outstanding initiator: simple req/rsp
// port in, channel A out, channel D consumed with watchdog.
module peripheral_master_tl
  import peripheral_tl_pkg::*;
#(
  parameter int TL_AW    = 32,
  parameter int TL_DW    = 32,
  parameter int TL_SRCW  = 8,
  parameter int TL_SINKW = 1,
  parameter int TL_DBW   = TL_DW >> 3,
  parameter int TL_SZW   = $clog2($clog2(TL_DBW) + 1),
  parameter int TIMEOUT  = 1024
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_we,
  input  logic [TL_AW-1:0]    req_addr,
  input  logic [TL_DBW-1:0]   req_be,
  input  logic [TL_DW-1:0]    req_wdata,
  output logic                rsp_valid,
  output logic [TL_DW-1:0]    rsp_rdata,
  output logic                rsp_err,
  output logic [2:0]          a_opcode,
  output logic [2:0]          a_param,
  output logic [TL_SZW-1:0]   a_size,
  output logic [TL_SRCW-1:0]  a_source,
  output logic [TL_AW-1:0]    a_address,
  output logic [TL_DBW-1:0]   a_mask,
  output logic [TL_DW-1:0]    a_data,
  output logic                a_corrupt,
  output logic                a_valid,
  input  logic                a_ready,
  input  logic [2:0]          d_opcode,
  input  logic [2:0]          d_param,
  input  logic [TL_SZW-1:0]   d_size,
  input  logic [TL_SRCW-1:0]  d_source,
  input  logic [TL_SINKW-1:0] d_sink,
  input  logic                d_denied,
  input  logic [TL_DW-1:0]    d_data,
  input  logic                d_corrupt,
  input  logic                d_valid,
  output logic                d_ready
);

  localparam logic [TL_SZW-1:0] FULL_SZ =
    TL_SZW'($clog2(TL_DBW));
  localparam int WDW =
    (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  tl_state_e           state_q;
  logic [TL_SRCW-1:0]  src_q;
  logic [WDW-1:0]      wd_q;
  logic                we_q;
  logic                a_valid_q;
  logic [2:0]          a_opcode_q;
  logic [TL_SZW-1:0]   a_size_q;
  logic [TL_AW-1:0]    a_address_q;
  logic [TL_DBW-1:0]   a_mask_q;
  logic [TL_DW-1:0]    a_data_q;
  logic                d_ready_q;
  logic                rsp_valid_q;
  logic                rsp_err_q;
  logic [TL_DW-1:0]    rsp_rdata_q;

  logic [2:0]          a_opcode_d;
  logic [TL_DBW-1:0]   a_mask_d;
  logic [TL_DW-1:0]    a_data_d;
  logic                d_hit;
  logic                err_d;
  logic [TL_DW-1:0]    rdata_d;
  logic                wd_exp;
  logic                unused_d;

  assign unused_d = ^{d_param, d_size, d_sink};

  // Reset gates the handshake outputs in the same cycle.
  assign req_ready = (state_q == S_IDLE) & ~reset;
  assign a_valid   = a_valid_q & ~reset;
  assign d_ready   = d_ready_q & ~reset;

  assign a_opcode  = a_opcode_q;
  assign a_param   = 3'd0;
  assign a_size    = a_size_q;
  assign a_source  = src_q;
  assign a_address = a_address_q;
  assign a_mask    = a_mask_q;
  assign a_data    = a_data_q;
  assign a_corrupt = 1'b0;

  assign rsp_valid = rsp_valid_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_rdata = rsp_rdata_q;

  always_comb begin
    a_opcode_d = GET;
    a_mask_d   = '1;
    a_data_d   = '0;
    if (req_we) begin
      a_opcode_d = (&req_be) ? PUT_FULL : PUT_PARTIAL;
      a_mask_d   = req_be;
      a_data_d   = req_wdata;
    end
  end

  always_comb begin
    d_hit = d_valid & d_ready & (d_source == src_q);
    err_d = d_denied;
    if (we_q)
      err_d = err_d | (d_opcode != ACCESS_ACK);
    else
      err_d = err_d | d_corrupt |
              (d_opcode != ACCESS_ACK_DATA);
    rdata_d = (!we_q && !err_d) ? d_data : '0;
    wd_exp  = (TIMEOUT != 0) &&
              (int'(wd_q) == TIMEOUT - 1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      src_q       <= '0;
      wd_q        <= '0;
      we_q        <= 1'b0;
      a_valid_q   <= 1'b0;
      a_opcode_q  <= 3'd0;
      a_size_q    <= '0;
      a_address_q <= '0;
      a_mask_q    <= '0;
      a_data_q    <= '0;
      d_ready_q   <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      d_ready_q   <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
      unique case (state_q)
        S_IDLE: begin
          if (req_valid) begin
            we_q        <= req_we;
            a_valid_q   <= 1'b1;
            a_opcode_q  <= a_opcode_d;
            a_size_q    <= FULL_SZ;
            a_address_q <= req_addr;
            a_mask_q    <= a_mask_d;
            a_data_q    <= a_data_d;
            state_q     <= S_A_REQ;
          end
        end
        S_A_REQ: begin
          if (a_ready) begin
            a_valid_q <= 1'b0;
            wd_q      <= '0;
            state_q   <= S_D_WAIT;
          end
        end
        S_D_WAIT: begin
          // A matching beat beats a coincident timeout.
          if (d_hit) begin
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= err_d;
            rsp_rdata_q <= rdata_d;
            src_q       <= src_q + 1'b1;
            state_q     <= S_IDLE;
          end else if (wd_exp) begin
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= 1'b1;
            src_q       <= src_q + 1'b1;
            state_q     <= S_IDLE;
          end else if (TIMEOUT != 0) begin
            wd_q <= wd_q + 1'b1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_peripheral_master_tl.sv
// Directed plus randomized bench for peripheral_master_tl
// against a transaction-level reference model.
module tb_peripheral_master_tl;

  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [31:0] req_addr = '0;
  logic [3:0]  req_be = '0;
  logic [31:0] req_wdata = '0;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [2:0]  a_opcode;
  logic [2:0]  a_param;
  logic [1:0]  a_size;
  logic [7:0]  a_source;
  logic [31:0] a_address;
  logic [3:0]  a_mask;
  logic [31:0] a_data;
  logic        a_corrupt;
  logic        a_valid;
  logic        a_ready = 1'b0;
  logic [2:0]  d_opcode = '0;
  logic [2:0]  d_param = '0;
  logic [1:0]  d_size = 2'd2;
  logic [7:0]  d_source = '0;
  logic [0:0]  d_sink = '0;
  logic        d_denied = 1'b0;
  logic [31:0] d_data = '0;
  logic        d_corrupt = 1'b0;
  logic        d_valid = 1'b0;
  logic        d_ready;

  int nvec = 0;
  int nerr = 0;
  int src_m = 0;

  peripheral_master_tl #(.TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_addr(req_addr),
    .req_be(req_be), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err),
    .a_opcode(a_opcode), .a_param(a_param),
    .a_size(a_size), .a_source(a_source),
    .a_address(a_address), .a_mask(a_mask),
    .a_data(a_data), .a_corrupt(a_corrupt),
    .a_valid(a_valid), .a_ready(a_ready),
    .d_opcode(d_opcode), .d_param(d_param),
    .d_size(d_size), .d_source(d_source),
    .d_sink(d_sink), .d_denied(d_denied),
    .d_data(d_data), .d_corrupt(d_corrupt),
    .d_valid(d_valid), .d_ready(d_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [127:0] obs,
                     input logic [127:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference rules for the A channel and the response.
  function automatic logic [2:0] m_op(input logic we,
                                      input logic [3:0] be);
    if (!we) return 3'd4;
    return (be == 4'hF) ? 3'd0 : 3'd1;
  endfunction

  function automatic logic m_err(input logic we,
                                 input logic [2:0] op,
                                 input logic den,
                                 input logic cor);
    if (den) return 1'b1;
    if (we) return op != 3'd0;
    return cor || (op != 3'd1);
  endfunction

  function automatic logic [127:0] m_pay(
      input logic we, input logic [31:0] addr,
      input logic [3:0] be, input logic [31:0] wd);
    logic [3:0]  mk;
    logic [31:0] dt;
    logic [7:0]  s;
    mk = we ? be : 4'hF;
    dt = we ? wd : 32'd0;
    s  = 8'(src_m);
    return {m_op(we, be), 3'd0, 2'd2, s,
            addr, mk, dt, 1'b0};
  endfunction

  task automatic req_hs(input logic we,
                        input logic [31:0] addr,
                        input logic [3:0] be,
                        input logic [31:0] wd);
    int n;
    n = 0;
    while (!req_ready && n < 50) begin
      tick();
      n++;
    end
    chk("req_ready_idle", req_ready, 1'b1);
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_be    = be;
    req_wdata = wd;
    tick();
    req_valid = 1'b0;
    chk("a_valid_lat", a_valid, 1'b1);
    chk("a_payload",
        {a_opcode, a_param, a_size, a_source,
         a_address, a_mask, a_data, a_corrupt},
        m_pay(we, addr, be, wd));
  endtask

  task automatic issue(input logic we,
                       input logic [31:0] addr,
                       input logic [3:0] be,
                       input logic [31:0] wd,
                       input int hold);
    req_hs(we, addr, be, wd);
    for (int i = 0; i < hold; i++) begin
      if (i == 0) begin
        // Beat during A_REQ, even with our source, is stale.
        d_valid  = 1'b1;
        d_source = 8'(src_m);
        d_opcode = we ? 3'd0 : 3'd1;
      end
      tick();
      d_valid = 1'b0;
      chk("a_hold_valid", a_valid, 1'b1);
      chk("a_hold_pay",
          {a_opcode, a_param, a_size, a_source,
           a_address, a_mask, a_data, a_corrupt},
          m_pay(we, addr, be, wd));
      chk("a_hold_norsp", rsp_valid, 1'b0);
    end
    a_ready = 1'b1;
    tick();
    a_ready = 1'b0;
    chk("a_valid_drop", a_valid, 1'b0);
  endtask

  task automatic respond(input logic we, input int delay,
                         input logic [2:0] op,
                         input logic den, input logic cor,
                         input logic [31:0] data,
                         input bit stale);
    logic e;
    for (int i = 0; i < delay; i++) begin
      tick();
      chk("wait_norsp", rsp_valid, 1'b0);
    end
    if (stale) begin
      d_valid  = 1'b1;
      d_source = 8'(src_m + 1);
      d_opcode = op;
      d_data   = ~data;
      tick();
      d_valid = 1'b0;
      chk("stale_drop", rsp_valid, 1'b0);
    end
    chk("d_ready", d_ready, 1'b1);
    d_valid   = 1'b1;
    d_source  = 8'(src_m);
    d_opcode  = op;
    d_denied  = den;
    d_corrupt = cor;
    d_data    = data;
    tick();
    d_valid   = 1'b0;
    d_denied  = 1'b0;
    d_corrupt = 1'b0;
    e = m_err(we, op, den, cor);
    chk("rsp_valid", rsp_valid, 1'b1);
    chk("rsp_err", rsp_err, e);
    chk("rsp_rdata", rsp_rdata,
        (!we && !e) ? data : 32'd0);
    chk("req_ready_rsp", req_ready, 1'b1);
    src_m = (src_m + 1) % 256;
    tick();
    chk("rsp_pulse", rsp_valid, 1'b0);
  endtask

  initial begin
    int n;
    int old;
    logic        we;
    logic [3:0]  be;
    logic [31:0] ad;
    logic [31:0] wd;
    logic [31:0] dd;
    logic [2:0]  op;
    logic        den;
    logic        cor;

    repeat (3) tick();
    chk("rst_req_ready", req_ready, 1'b0);
    chk("rst_a_valid", a_valid, 1'b0);
    chk("rst_d_ready", d_ready, 1'b0);
    chk("rst_rsp",
        {rsp_valid, rsp_err, rsp_rdata}, 34'd0);
    chk("rst_a_pay",
        {a_opcode, a_size, a_source,
         a_address, a_mask, a_data}, 85'd0);
    reset = 1'b0;
    tick();
    chk("post_rst_req_ready", req_ready, 1'b1);
    chk("post_rst_d_ready", d_ready, 1'b1);

    issue(1'b0, 32'h100, 4'h0, 32'h0, 0);
    respond(1'b0, 3, 3'd1, 1'b0, 1'b0,
            32'hDEADBEEF, 1'b0);

    issue(1'b1, 32'h200, 4'hF, 32'h12345678, 0);
    respond(1'b1, 1, 3'd0, 1'b0, 1'b0, 32'h0, 1'b0);
    issue(1'b1, 32'h204, 4'h3, 32'h12345678, 0);
    respond(1'b1, 0, 3'd0, 1'b0, 1'b0, 32'h0, 1'b0);

    issue(1'b1, 32'h300, 4'h5, 32'hA5A5A5A5, 10);
    respond(1'b1, 2, 3'd0, 1'b0, 1'b0, 32'h0, 1'b1);

    issue(1'b0, 32'h400, 4'h0, 32'h0, 0);
    n = 0;
    while (!rsp_valid && n < 40) begin
      tick();
      n++;
    end
    chk("to_cycles", n, TO);
    chk("to_err", rsp_err, 1'b1);
    chk("to_rdata", rsp_rdata, 32'd0);
    old = src_m;
    src_m = (src_m + 1) % 256;
    tick();
    d_valid  = 1'b1;
    d_source = 8'(old);
    d_opcode = 3'd1;
    d_data   = 32'h0BAD0BAD;
    tick();
    d_valid = 1'b0;
    chk("late_drop", rsp_valid, 1'b0);
    issue(1'b0, 32'h404, 4'h0, 32'h0, 0);
    respond(1'b0, 0, 3'd1, 1'b0, 1'b0,
            32'hCAFEF00D, 1'b0);

    issue(1'b0, 32'h500, 4'h0, 32'h0, 0);
    respond(1'b0, 1, 3'd1, 1'b1, 1'b0,
            32'h11111111, 1'b0);
    issue(1'b0, 32'h504, 4'h0, 32'h0, 0);
    respond(1'b0, 1, 3'd1, 1'b0, 1'b1,
            32'h22222222, 1'b0);
    issue(1'b1, 32'h508, 4'hF, 32'h33333333, 0);
    respond(1'b1, 1, 3'd1, 1'b0, 1'b0, 32'h0, 1'b0);

    req_hs(1'b1, 32'h600, 4'hF, 32'h44444444);
    reset = 1'b1;
    #1;
    chk("rst_areq_a_valid", a_valid, 1'b0);
    tick();
    reset = 1'b0;
    tick();
    chk("rst_areq_norsp", rsp_valid, 1'b0);
    chk("rst_areq_idle", req_ready, 1'b1);
    src_m = 0;

    issue(1'b0, 32'h700, 4'h0, 32'h0, 0);
    tick();
    tick();
    reset = 1'b1;
    tick();
    chk("rst_dw_a_valid", a_valid, 1'b0);
    chk("rst_dw_norsp", rsp_valid, 1'b0);
    reset = 1'b0;
    tick();
    chk("rst_dw_idle", req_ready, 1'b1);
    chk("rst_dw_norsp2", rsp_valid, 1'b0);
    src_m = 0;
    issue(1'b0, 32'h704, 4'h0, 32'h0, 0);
    respond(1'b0, 0, 3'd1, 1'b0, 1'b0,
            32'h55AA55AA, 1'b0);

    for (int t = 0; t < 40; t++) begin
      we  = 1'($urandom_range(0, 1));
      be  = 4'($urandom_range(1, 15));
      ad  = $urandom & 32'hFFFF_FFFC;
      wd  = $urandom;
      dd  = $urandom;
      op  = we ? 3'd0 : 3'd1;
      if ($urandom_range(0, 3) == 0)
        op = 3'($urandom_range(0, 7));
      den = ($urandom_range(0, 7) == 0);
      cor = ($urandom_range(0, 5) == 0);
      issue(we, ad, be, wd, $urandom_range(0, 3));
      respond(we, $urandom_range(0, 10), op, den, cor,
              dd, 1'($urandom_range(0, 1)));
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             nvec, nerr);
    $finish;
  end

endmodule
